// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM state encoding,
// default register-address width and the ID/EX control-word layout.
package hazard_pkg;

  localparam int unsigned REG_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEMWAIT,
    ERROR
  } state_t;

  // ID/EX control word; IDEXFlush_o zeros the whole word to form a bubble.
  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    logic [3:0] ex;
  } idex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the
// instruction currently in ID. Register 0 never creates a hazard.
module load_use_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);

  always_comb begin
    hazard = ex_mem_read && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: start-up sequencing, load-use stalls,
// ID-resolved control flushes, memory-wait freeze with timeout watchdog.
// Optional stall-cycle counter is built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned TMO_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] IDRegRs_i,
  input  logic [REG_W-1:0] IDRegRt_i,
  input  logic             IDUsesRt_i,
  input  logic             EXMemRead_i,
  input  logic [REG_W-1:0] EXRegRt_i,
  input  logic             BranchTaken_i,
  input  logic             Jump_i,
  input  logic             DMemReq_i,
  input  logic             DMemAck_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXFlush_o,
  output logic             Freeze_o,
  output logic             Err_o,
  output logic [31:0]      StallCnt_o
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic             load_use;
  logic             mem_wait;
  logic             ctrl_xfer;
  logic             apply_run;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .ex_mem_read (EXMemRead_i),
    .ex_rt       (EXRegRt_i),
    .id_rs       (IDRegRs_i),
    .id_rt       (IDRegRt_i),
    .id_uses_rt  (IDUsesRt_i),
    .hazard      (load_use)
  );

  assign mem_wait  = DMemReq_i & ~DMemAck_i;
  assign ctrl_xfer = BranchTaken_i | Jump_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (mem_wait) begin
          // The RUN cycle that sees the request is the first wait cycle.
          tmr_d   = TMO_W'(1);
          state_d = (TMO_MAX == TMO_W'(1)) ? ERROR : MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (DMemAck_i) begin
          state_d = RUN;
        end else begin
          if (tmr_q != TMO_MAX) tmr_d = tmr_q + 1'b1;
          if (tmr_d == TMO_MAX) state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    IFIDFlush_o = 1'b0;
    IDEXFlush_o = 1'b0;
    Freeze_o    = 1'b0;
    Err_o       = 1'b0;
    apply_run   = 1'b0;
    unique case (state_q)
      IDLE: begin
        IFIDFlush_o = 1'b1;
        IDEXFlush_o = 1'b1;
      end
      RUN: begin
        if (mem_wait) Freeze_o  = 1'b1;
        else          apply_run = 1'b1;
      end
      MEMWAIT: begin
        if (!DMemAck_i) Freeze_o  = 1'b1;
        else            apply_run = 1'b1;
      end
      ERROR: begin
        Freeze_o = 1'b1;
        Err_o    = 1'b1;
      end
      default: ;
    endcase

    // Load-use wins over control transfer: the branch operand may be stale.
    if (apply_run) begin
      if (load_use) begin
        IDEXFlush_o = 1'b1;
      end else if (ctrl_xfer) begin
        IFIDFlush_o = 1'b1;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end else begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN || state_q == MEMWAIT) && !PCWrite_o &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCnt_o = stall_cnt_q;
`else
  assign StallCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with TMO_W=3.
module tb_hazard_ctrl;

  localparam int unsigned REG_W = 5;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Freeze, Err}
  localparam logic [5:0] IDLE_V = 6'b001100;
  localparam logic [5:0] RUN_V  = 6'b110000;
  localparam logic [5:0] LU_V   = 6'b000100;
  localparam logic [5:0] BR_V   = 6'b111000;
  localparam logic [5:0] FRZ_V  = 6'b000010;
  localparam logic [5:0] ERR_V  = 6'b000011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, br_taken, jump, dreq, dack;
  logic             pc_wr, ifid_wr, ifid_fl, idex_fl, freeze, err;
  logic [31:0]      stall_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .TMO_W(3)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .IDRegRs_i     (id_rs),
    .IDRegRt_i     (id_rt),
    .IDUsesRt_i    (id_uses_rt),
    .EXMemRead_i   (ex_mem_read),
    .EXRegRt_i     (ex_rt),
    .BranchTaken_i (br_taken),
    .Jump_i        (jump),
    .DMemReq_i     (dreq),
    .DMemAck_i     (dack),
    .PCWrite_o     (pc_wr),
    .IFIDWrite_o   (ifid_wr),
    .IFIDFlush_o   (ifid_fl),
    .IDEXFlush_o   (idex_fl),
    .Freeze_o      (freeze),
    .Err_o         (err),
    .StallCnt_o    (stall_cnt)
  );

  task automatic clr_in();
    start = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; br_taken = 1'b0; jump = 1'b0;
    dreq = 1'b0; dack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {pc_wr, ifid_wr, ifid_fl, idex_fl, freeze, err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    checks++;
    assert (stall_cnt === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, stall_cnt, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    chk("reset_state", IDLE_V);
    chk_cnt("reset_cnt", 32'd0);
    step(); step();
    rst_n = 1'b1;
    step(); chk("idle_hold", IDLE_V);
    step(); start = 1'b1; chk("start_cycle", IDLE_V);
    step(); start = 1'b0; chk("first_fetch", RUN_V);

    // Load-use on rs, then clears with no state
    step(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; chk("lu_rs", LU_V);
    step(); clr_in(); chk("lu_clear", RUN_V);
    step(); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; chk("lu_r0", RUN_V);

    // Taken branch and jump
    step(); clr_in(); br_taken = 1'b1; chk("branch", BR_V);
    step(); clr_in(); chk("branch_once", RUN_V);
    step(); jump = 1'b1; chk("jump", BR_V);

    // Branch during load-use on rt
    step(); clr_in(); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
    id_uses_rt = 1'b1; br_taken = 1'b1; chk("br_lu_rt", LU_V);
    step(); id_uses_rt = 1'b0; chk("br_rt_unused", BR_V);

    // Single-cycle memory access
    step(); clr_in(); dreq = 1'b1; dack = 1'b1; chk("mem_1cyc", RUN_V);
    step(); clr_in(); chk("mem_1cyc_after", RUN_V);

    // Memory wait of 3 cycles
    step(); dreq = 1'b1; chk("mw3_c1", FRZ_V);
    step(); chk("mw3_c2", FRZ_V);
    step(); chk("mw3_c3", FRZ_V);
    step(); dack = 1'b1; chk("mw3_ack", RUN_V);
    step(); clr_in(); chk("mw3_run", RUN_V);

    // Ack cycle applies load-use rule on current inputs
    step(); dreq = 1'b1; chk("mw_lu_c1", FRZ_V);
    step(); dack = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    chk("mw_lu_ack", LU_V);
    step(); clr_in(); chk("mw_lu_run", RUN_V);

    // Timeout: 7 wait cycles then ERROR
    for (int i = 1; i <= 7; i++) begin
      step(); dreq = 1'b1; chk($sformatf("tmo_wait%0d", i), FRZ_V);
    end
    step(); chk("tmo_err", ERR_V);
    step(); clr_in(); start = 1'b1; dack = 1'b1; chk("err_sticky", ERR_V);
    step(); clr_in(); chk("err_sticky2", ERR_V);
    #2; rst_n = 1'b0; chk("err_async_rst", IDLE_V);
    step(); rst_n = 1'b1;
    step(); start = 1'b1; chk("restart", IDLE_V);
    step(); start = 1'b0; chk("restart_run", RUN_V);

    // Reset mid-MEMWAIT, then a 6-cycle wait must not time out
    step(); dreq = 1'b1; chk("mwr_c1", FRZ_V);
    step(); chk("mwr_c2", FRZ_V);
    step(); chk("mwr_c3", FRZ_V);
    #2; rst_n = 1'b0; chk("mw_async_rst", IDLE_V);
    step(); clr_in(); rst_n = 1'b1;
    step(); start = 1'b1;
    step(); start = 1'b0; chk("rerun", RUN_V);
    for (int i = 1; i <= 6; i++) begin
      step(); dreq = 1'b1; chk($sformatf("mw6_c%0d", i), FRZ_V);
    end
    step(); dack = 1'b1; chk("mw6_ack", RUN_V);
    step(); clr_in(); chk("mw6_run", RUN_V);
`ifndef HAZARD_CTRL_PERF_EN
    chk_cnt("cnt_tied0", 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the forwarding unit and drives the PC, IF/ID and ID/EX write and flush controls. It also owns the global pipeline freeze while the data memory has an access outstanding, and a timeout watchdog on that access. It sequences start-up and detects load-use hazards and taken branches/jumps resolved in ID.

## Interface
Parameters:
- REG_W, 5: register-address width.
- TMO_W, 8: width of the memory-wait timer. Timeout fires after 2^TMO_W-1 wait cycles.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset; asynchronous assert, active-low
- start_i  in  1  leave IDLE and begin fetching
- IDRegRs_i  in  REG_W  rs of the instruction in ID
- IDRegRt_i  in  REG_W  rt of the instruction in ID
- IDUsesRt_i  in  1  ID instruction reads rt (R-type, beq, sw)
- EXMemRead_i  in  1  instruction in EX is a load
- EXRegRt_i  in  REG_W  load destination in EX
- BranchTaken_i  in  1  branch in ID resolved taken
- Jump_i  in  1  jump decoded in ID
- DMemReq_i  in  1  MEM stage has a read or write in flight
- DMemAck_i  in  1  data memory completes the access this cycle
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register enable
- IFIDFlush_o  out  1  IF/ID becomes a bubble
- IDEXFlush_o  out  1  ID/EX control fields zeroed
- Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- Err_o  out  1  memory-wait timeout, sticky
- StallCnt_o  out  32  stall-cycle counter (see Configuration)

## Operation
- State machine: IDLE, RUN, MEMWAIT, ERROR. The state is registered. Outputs are combinational from the state and the inputs.
- **IDLE**
  - Outputs: PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=1, IDEXFlush_o=1, Freeze_o=0, Err_o=0.
  - Goes to RUN on start_i=1.
- **RUN** applies the first matching rule below.
  1. Memory wait: DMemReq_i=1 and DMemAck_i=0.
     - Outputs: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, no flushes.
     - Goes to MEMWAIT. The timer loads 1.
  2. Load-use: EXMemRead_i=1, EXRegRt_i≠0, and EXRegRt_i==IDRegRs_i or (IDUsesRt_i=1 and EXRegRt_i==IDRegRt_i).
     - Outputs: PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1.
     - A BranchTaken_i or Jump_i in the same cycle is ignored, because the branch operand may be stale. It re-resolves next cycle.
  3. Control: BranchTaken_i=1 or Jump_i=1.
     - Outputs: IFIDFlush_o=1, PCWrite_o=1, IFIDWrite_o=1.
  4. Otherwise: PCWrite_o=1, IFIDWrite_o=1, no flush, no freeze.
- **MEMWAIT**
  - While DMemAck_i=0, outputs match rule 1 and the timer increments.
  - On the DMemAck_i=1 cycle: Freeze_o=0, and the RUN rules 2–4 are evaluated on the current inputs. Goes to RUN.
  - If the timer reaches 2^TMO_W-1 with DMemAck_i=0, goes to ERROR.
- **ERROR**
  - Outputs: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, Err_o=1.
  - Exits only on reset.
- start_i is ignored outside IDLE.

## Timing
- Reset values equal the IDLE outputs: PCWrite_o 0, IFIDWrite_o 0, IFIDFlush_o 1, IDEXFlush_o 1, Freeze_o 0, Err_o 0, StallCnt_o 0, timer 0.
- Zero-latency hazard response: stall and flush controls assert in the same cycle the condition appears.
- Load-use always inserts exactly one bubble. In the next cycle the load has moved to MEM, so the condition clears without any state.
- A single-cycle memory access (DMemReq_i and DMemAck_i together) causes no stall and no state change.
- A memory wait of N cycles (ack arriving N cycles after req) freezes for exactly N cycles.
- Reset asserted mid-MEMWAIT or in ERROR returns to IDLE asynchronously and clears the timer and Err_o.
- The timer saturates and never wraps.
- The first PC increment happens in the cycle after start_i is sampled.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - StallCnt_o counts cycles in RUN or MEMWAIT with PCWrite_o=0.
  - The count saturates at 2^32-1 and clears on reset.
- Undefined: StallCnt_o is tied to 0 and no counter flops are built.

## Structure
- Package hazard_pkg holds:
  - the state typedef (IDLE, RUN, MEMWAIT, ERROR);
  - REG_W_DEF=5;
  - the bit layout of the ID/EX control word (WB[1:0], M[1:0], EX[3:0]) that IDEXFlush_o zeros.
- Sub-module load_use_detect: combinational rule-2 comparator. It is reused by the verification scoreboard.

## Test plan
- **Reset/start:** hold rst_n_i=0, then release.
  - Outputs stay at IDLE values until start_i=1.
  - In the next cycle PCWrite_o=1 and IFIDWrite_o=1.
- **Load-use:**
  - Stimulus: EXMemRead_i=1, EXRegRt_i=8, IDRegRs_i=8.
  - Response: PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1 for one cycle.
  - Same with EXRegRt_i=0: no stall.
- **Taken branch:** BranchTaken_i=1 with no hazard gives IFIDFlush_o=1 and PCWrite_o=1 for that cycle only.
- **Branch during load-use:**
  - Stimulus: EXRegRt_i=9=IDRegRt_i, IDUsesRt_i=1, BranchTaken_i=1.
  - Response: stall asserted and IFIDFlush_o=0.
- **Memory wait:** DMemReq_i=1 with DMemAck_i arriving 3 cycles later gives Freeze_o=1 for exactly 3 cycles, then a return to RUN.
- **Timeout, TMO_W=3:**
  - Stimulus: DMemReq_i=1 held with no ack.
  - Response: Err_o=1 after 7 wait cycles. Outputs are stuck until rst_n_i=0, which returns IDLE values.
